// File: rtl/gshare_branch_predictor.sv
// -----------------------------------------------------------------------------
// gshare_branch_predictor
//
// Direction predictor built around a pattern history table (PHT) of 2-bit
// saturating counters. After reset the table is swept once, one entry per
// cycle, to CTR_INIT; only then does the predictor accept lookups/updates.
//
// Build option:
//   GSHARE_BRANCH_PREDICTOR_XOR_EN
//     defined   : PHT index = pc[IDX_WIDTH+1:2] ^ zero-extended history (gshare)
//     undefined : PHT index = pc[IDX_WIDTH+1:2]                          (bimodal)
//   The global history register is maintained and reported in both builds.
//
// Ports:
//   clk, rst                async active-high reset
//   isReady                 table initialised, predictor running
//   lookupValid/lookupPc    fetch request
//   predictValid            registered response, one cycle after the request
//   isBranchTakenPredicted  counter MSB of the looked-up entry
//   globalBranchHistory     GHR value used for that prediction
//   updateValid/updatePc/updateHistory/updateTaken
//                           resolved branch from execute
// -----------------------------------------------------------------------------
module gshare_branch_predictor #(
   parameter int         PC_WIDTH    = 32,
   parameter int         HISTORY_LEN = 4,
   parameter int         PHT_ENTRIES = 64,
   parameter logic [1:0] CTR_INIT    = 2'b01
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   isReady,
   input  logic                   lookupValid,
   input  logic [PC_WIDTH-1:0]    lookupPc,
   output logic                   predictValid,
   output logic                   isBranchTakenPredicted,
   output logic [HISTORY_LEN-1:0] globalBranchHistory,
   input  logic                   updateValid,
   input  logic [PC_WIDTH-1:0]    updatePc,
   input  logic [HISTORY_LEN-1:0] updateHistory,
   input  logic                   updateTaken
);

   localparam int                   IDX_WIDTH = $clog2(PHT_ENTRIES);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(PHT_ENTRIES - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                 r_state, w_state_next;
   logic [IDX_WIDTH-1:0]   r_init_cnt;
   logic [HISTORY_LEN-1:0] r_ghr;
   logic [HISTORY_LEN-1:0] w_ghr_shift;
   logic [1:0]             r_pht [PHT_ENTRIES];

   logic                   r_pred_valid;
   logic                   r_pred_taken;
   logic [HISTORY_LEN-1:0] r_hist_out;

   logic                   w_run;
   logic [IDX_WIDTH-1:0]   w_lk_idx;
   logic [IDX_WIDTH-1:0]   w_up_idx;
   logic [1:0]             w_ctr_cur;
   logic [1:0]             w_ctr_next;
   logic                   w_unused;

   assign w_run = (r_state == S_RUN);

`ifdef GSHARE_BRANCH_PREDICTOR_XOR_EN
   assign w_lk_idx = lookupPc[IDX_WIDTH+1:2] ^ IDX_WIDTH'(r_ghr);
   assign w_up_idx = updatePc[IDX_WIDTH+1:2] ^ IDX_WIDTH'(updateHistory);
   assign w_unused = ^{lookupPc[PC_WIDTH-1:IDX_WIDTH+2], lookupPc[1:0],
                       updatePc[PC_WIDTH-1:IDX_WIDTH+2], updatePc[1:0]};
`else
   assign w_lk_idx = lookupPc[IDX_WIDTH+1:2];
   assign w_up_idx = updatePc[IDX_WIDTH+1:2];
   assign w_unused = ^{lookupPc[PC_WIDTH-1:IDX_WIDTH+2], lookupPc[1:0],
                       updatePc[PC_WIDTH-1:IDX_WIDTH+2], updatePc[1:0],
                       updateHistory};
`endif

   // A 1-bit history has nothing to keep from the old value.
   generate
      if (HISTORY_LEN == 1) begin : g_ghr1
         assign w_ghr_shift = updateTaken;
      end else begin : g_ghrn
         assign w_ghr_shift = {r_ghr[HISTORY_LEN-2:0], updateTaken};
      end
   endgenerate

   // Saturating counter step for the entry being updated.
   always_comb begin
      w_ctr_cur  = r_pht[w_up_idx];
      w_ctr_next = w_ctr_cur;
      if (updateTaken) begin
         if (w_ctr_cur != 2'd3) w_ctr_next = w_ctr_cur + 2'd1;
      end else begin
         if (w_ctr_cur != 2'd0) w_ctr_next = w_ctr_cur - 2'd1;
      end
   end

   // FSM next state: INIT leaves once the last entry is written.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_INIT:  if (r_init_cnt == LAST_IDX) w_state_next = S_RUN;
         S_RUN:   w_state_next = S_RUN;
         default: w_state_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_INIT;
         r_init_cnt   <= '0;
         r_ghr        <= '0;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_hist_out   <= '0;
      end else begin
         r_state <= w_state_next;
         if (!w_run) r_init_cnt <= r_init_cnt + 1'b1;

         // Lookup reads the pre-update counter and GHR: a same-cycle update
         // only lands at this edge, so read-before-write comes for free.
         r_pred_valid <= lookupValid && w_run;
         if (lookupValid && w_run) begin
            r_pred_taken <= r_pht[w_lk_idx][1];
            r_hist_out   <= r_ghr;
         end

         if (updateValid && w_run) r_ghr <= w_ghr_shift;
      end
   end

   // Table storage needs no reset: the INIT sweep defines every entry.
   always_ff @(posedge clk) begin
      if (!w_run)
         r_pht[r_init_cnt] <= CTR_INIT;
      else if (updateValid)
         r_pht[w_up_idx] <= w_ctr_next;
   end

   assign isReady                = w_run;
   assign predictValid           = r_pred_valid;
   assign isBranchTakenPredicted = r_pred_taken;
   assign globalBranchHistory    = r_hist_out;

endmodule
